ssd_scan_driver: RTL and testbench

Time-multiplexed driver for a DIGITS-wide common-anode seven-segment display bank. It latches one 5-bit glyph code per digit and decodes it to abcdefg. It then scans the digits one at a time with a ghosting guard, per-digit decimal points and per-digit blinking. It replaces the per-digit combinational decoders: the display panel of the queue system instantiates one of these directly on the board pins.

---
 rtl/ssd_scan_driver.sv | 165 ++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_driver.sv
// Seven-segment bank driver: latches a 5-bit glyph per digit, decodes to abcdefg,
// and scans the common-anode digits with a dark guard at the start of each slot.
module ssd_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2,
  parameter int BLINK_SCANS = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [5*DIGITS-1:0]   glyphs,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blink_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX  = IW'(DIGITS - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_SCANS - 1);

  logic [4:0]        glyph_q [DIGITS];
  logic [DIGITS-1:0] dpreq_q;
  logic [DIGITS-1:0] blink_q;

  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [BW-1:0]     bcnt_q,  bcnt_d;
  logic              phase_q, phase_d;

  logic [DIGITS-1:0] an_q,    an_d;
  logic [6:0]        seg_q,   seg_d;
  logic              dp_q,    dp_d;

  function automatic logic [6:0] glyph_to_seg(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'b0000001;
      5'd1:    s = 7'b1001111;
      5'd2:    s = 7'b0010010;
      5'd3:    s = 7'b0000110;
      5'd4:    s = 7'b1001100;
      5'd5:    s = 7'b0100100;
      5'd6:    s = 7'b0100000;
      5'd7:    s = 7'b0001111;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0000100;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b1100000;
      5'd12:   s = 7'b0110001;
      5'd13:   s = 7'b1000010;
      5'd14:   s = 7'b0110000;
      5'd15:   s = 7'b0111000;
      5'd16:   s = 7'b1100010;
      5'd17:   s = 7'b1110001;
      5'd18:   s = 7'b0011000;
      5'd19:   s = 7'b1101000;
      5'd20:   s = 7'b1111010;
      5'd21:   s = 7'b1111110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Slot, digit and blink counters; all hold while enable is low.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (enable) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        if (idx_q == IDX_MAX) begin
          idx_d = '0;
          if (bcnt_q == BCNT_MAX) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next output drive, computed from the pre-edge counters and latched data.
  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (enable && (cnt_q >= GUARD_C)) begin
      an_d[idx_q] = 1'b0;
      // A blinked digit keeps its anode so the scan timing looks the same.
      if (phase_q && blink_q[idx_q]) begin
        seg_d = 7'h7F;
        dp_d  = 1'b1;
      end else begin
        seg_d = glyph_to_seg(glyph_q[idx_q]);
        dp_d  = ~dpreq_q[idx_q];
      end
    end else begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end
  end

  // Glyph, decimal point and blink latches; reset leaves every digit blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        glyph_q[i] <= 5'h1F;
      end
      dpreq_q <= '0;
      blink_q <= '0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        glyph_q[i] <= glyphs[5*i +: 5];
      end
      dpreq_q <= dp_in;
      blink_q <= blink_en;
    end
  end

  // Scan state and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      an_q    <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: per-cycle scoreboard against an arithmetic scan model,
// plus table-driven glyph/scan checks and hand sequences for enable, blink and reset.
module tb_ssd_scan_driver;

  localparam int DIGITS = 4;
  localparam int RDIV   = 8;
  localparam int GRD    = 2;
  localparam int BSCANS = 2;

  logic        clk = 1'b0;
  logic        rst, enable, load;
  logic [19:0] glyphs;
  logic [3:0]  dp_in, blink_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  ssd_scan_driver #(
    .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .GUARD(GRD), .BLINK_SCANS(BSCANS)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .glyphs(glyphs),
    .dp_in(dp_in), .blink_en(blink_en), .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] code; logic [6:0] seg; } glyph_vec_t;
  typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; } scan_vec_t;

  glyph_vec_t  gtab [25];
  scan_vec_t   stab [4];
  logic [6:0]  exp_map [32];
  logic [11:0] sb_q [$];

  int checks = 0;
  int errors = 0;

  // bench model state
  int         m_a;
  logic [4:0] m_glyph [4];
  logic [3:0] m_dp, m_blink;

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [11:0] e, g;
    int cnt, idx, ph;
    e = {4'hF, 7'h7F, 1'b1};
    if (rst) begin
      m_a = 0;
      for (int i = 0; i < 4; i++) m_glyph[i] = 5'h1F;
      m_dp = 4'b0000;
      m_blink = 4'b0000;
    end else begin
      cnt = m_a % RDIV;
      idx = (m_a / RDIV) % DIGITS;
      ph  = (m_a / (RDIV * DIGITS * BSCANS)) % 2;
      if (enable && cnt >= GRD) begin
        e[11:8] = ~(4'b0001 << idx);
        if (ph == 1 && m_blink[idx]) begin
          e[7:0] = {7'h7F, 1'b1};
        end else begin
          e[7:0] = {exp_map[m_glyph[idx]], ~m_dp[idx]};
        end
      end
      if (enable) m_a++;
      if (load) begin
        for (int i = 0; i < 4; i++) m_glyph[i] = glyphs[5*i +: 5];
        m_dp = dp_in;
        m_blink = blink_en;
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = {an, seg, dp};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at t=%0t", $time);
    end else begin
      e = sb_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 $time, g[11:8], g[7:1], g[0], e[11:8], e[7:1], e[0]);
      end
    end
    checks++;
    if ($countones(~an) > 1) begin
      errors++;
      $display("FAIL one_anode: got an=%b, expected at most one low bit", an);
    end
  endtask

  task automatic wait_an(input logic [3:0] target, input string name);
    bit hit = 1'b0;
    for (int n = 0; n < 64 && !hit; n++) begin
      step();
      if (an === target) hit = 1'b1;
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for an=%b, got an=%b", name, target, an);
    end
  endtask

  initial begin
    int lit_blank, lit_shown;
    bit seen;
    gtab[0]  = '{5'd0,  7'b0000001}; gtab[1]  = '{5'd1,  7'b1001111};
    gtab[2]  = '{5'd2,  7'b0010010}; gtab[3]  = '{5'd3,  7'b0000110};
    gtab[4]  = '{5'd4,  7'b1001100}; gtab[5]  = '{5'd5,  7'b0100100};
    gtab[6]  = '{5'd6,  7'b0100000}; gtab[7]  = '{5'd7,  7'b0001111};
    gtab[8]  = '{5'd8,  7'b0000000}; gtab[9]  = '{5'd9,  7'b0000100};
    gtab[10] = '{5'd10, 7'b0001000}; gtab[11] = '{5'd11, 7'b1100000};
    gtab[12] = '{5'd12, 7'b0110001}; gtab[13] = '{5'd13, 7'b1000010};
    gtab[14] = '{5'd14, 7'b0110000}; gtab[15] = '{5'd15, 7'b0111000};
    gtab[16] = '{5'd16, 7'b1100010}; gtab[17] = '{5'd17, 7'b1110001};
    gtab[18] = '{5'd18, 7'b0011000}; gtab[19] = '{5'd19, 7'b1101000};
    gtab[20] = '{5'd20, 7'b1111010}; gtab[21] = '{5'd21, 7'b1111110};
    gtab[22] = '{5'd22, 7'b1111111}; gtab[23] = '{5'd26, 7'b1111111};
    gtab[24] = '{5'd31, 7'b1111111};
    stab[0] = '{4'b1110, 7'b0100100, 1'b1};
    stab[1] = '{4'b1101, 7'b1001111, 1'b0};
    stab[2] = '{4'b1011, 7'b0001000, 1'b1};
    stab[3] = '{4'b0111, 7'b1101000, 1'b1};
    for (int i = 0; i < 32; i++) exp_map[i] = 7'h7F;
    for (int i = 0; i < 25; i++) exp_map[gtab[i].code] = gtab[i].seg;

    rst = 1'b1; enable = 1'b1; load = 1'b0;
    glyphs = '1; dp_in = 4'b0000; blink_en = 4'b0000;

    // reset: three cycles held, then the first slot of digit 0 with a blank glyph
    repeat (3) step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e <= 2) chk("reset_guard", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
      else        chk("reset_blank", {an, seg, dp}, {4'b1110, 7'h7F, 1'b1});
    end

    // load and scan
    glyphs = {5'd19, 5'd10, 5'd1, 5'd5}; dp_in = 4'b0010; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_an(stab[i].an, "scan_wait");
      chk("scan_digit", {an, seg, dp}, {stab[i].an, stab[i].seg, stab[i].dp});
    end

    // blink digit 2
    blink_en = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    lit_blank = 0; lit_shown = 0;
    for (int n = 0; n < 140; n++) begin
      step();
      if (an === 4'b1011 && seg === 7'h7F) lit_blank++;
      if (an === 4'b1011 && seg === 7'b0001000) lit_shown++;
    end
    chk("blink_dark_seen", {11'd0, lit_blank > 0}, 12'd1);
    chk("blink_lit_seen",  {11'd0, lit_shown > 0}, 12'd1);

    // enable gate mid-slot on digit 0
    wait_an(4'b1101, "en_wait_d1");
    wait_an(4'b1110, "en_wait_d0");
    repeat (2) step();
    enable = 1'b0;
    step();
    chk("enable_dark", {8'd0, an}, {8'd0, 4'b1111});
    repeat (4) step();
    enable = 1'b1;
    step();
    chk("enable_resume", {8'd0, an}, {8'd0, 4'b1110});
    repeat (10) step();

    // glyph code table on digit 0
    blink_en = 4'b0000; dp_in = 4'b0000;
    for (int i = 0; i < 25; i++) begin
      glyphs = {15'h7FFF, gtab[i].code}; load = 1'b1;
      step();
      load = 1'b0;
      wait_an(4'b1110, "code_wait");
      chk($sformatf("code_%0d", gtab[i].code), {5'd0, seg}, {5'd0, gtab[i].seg});
    end

    // reset mid-scan at digit 2, then load colliding with reset
    glyphs = {5'd3, 5'd2, 5'd1, 5'd0}; load = 1'b1;
    step();
    load = 1'b0;
    wait_an(4'b1011, "rst_wait_d2");
    rst = 1'b1;
    step();
    chk("rst_mid_dark", {8'd0, an}, {8'd0, 4'b1111});
    glyphs = {4{5'd8}}; dp_in = 4'b1111; load = 1'b1;
    step();
    rst = 1'b0; load = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 16 && !seen; n++) begin
      step();
      if (an !== 4'b1111) seen = 1'b1;
    end
    chk("rst_restart_d0", {an, seg, dp}, {4'b1110, 7'h7F, 1'b1});
    wait_an(4'b1101, "rst_wait_d1");
    chk("rst_load_blank", {an, seg, dp}, {4'b1101, 7'h7F, 1'b1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
